// File: rtl/button_input_regs_pkg.sv
// Shared constants for the button/switch input responder: register indices,
// default debounce period and the bus handshake state type.
package button_input_regs_pkg;

  localparam int DEFAULT_DEBOUNCE_PERIOD = 5_000_000;

  localparam logic [1:0] BTN_REG_STATE  = 2'd0;
  localparam logic [1:0] BTN_REG_RISE   = 2'd1;
  localparam logic [1:0] BTN_REG_FALL   = 2'd2;
  localparam logic [1:0] BTN_REG_CONFIG = 2'd3;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

endpackage

// File: rtl/wishbone.sv
// Wishbone classic bus bundle shared by the user I/O responders.
interface wishbone;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;

  modport slave  (input cyc, stb, we, adr, dat_w, output dat_r, ack);
  modport master (output cyc, stb, we, adr, dat_w, input dat_r, ack);
endinterface

// File: rtl/button_input_regs_debouncer.sv
// One-bit synchroniser plus debouncer; `change` flags the cycle whose closing
// edge will flip `out`, so edge flags can be set on that very edge.
module button_input_regs_debouncer #(
  parameter int PERIOD = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in,
  output logic out,
  output logic change
);

  localparam int CNT_W = $clog2(PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             deb_r;
  logic [CNT_W-1:0] cnt_r;

  // Two-stage synchroniser and stability counter; a glitch back to deb restarts it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      deb_r   <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      sync1_r <= in;
      sync2_r <= sync1_r;
      if (sync2_r == deb_r) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_r == CNT_LAST) begin
        deb_r <= sync2_r;
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign out    = deb_r;
  assign change = (sync2_r != deb_r) && (cnt_r == CNT_LAST);

endmodule

// File: rtl/button_input_regs.sv
// Wishbone classic responder exposing debounced buttons/switches plus sticky
// write-1-to-clear rise/fall flags.
module button_input_regs
  import button_input_regs_pkg::*;
#(
  parameter int DEBOUNCE_PERIOD = DEFAULT_DEBOUNCE_PERIOD,
  parameter int N_BUTTONS       = 4,
  parameter int N_SWITCHES      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N_BUTTONS-1:0]  buttons,
  input  logic [N_SWITCHES-1:0] switches,
  wishbone.slave                wb
);

  localparam int N = N_BUTTONS + N_SWITCHES;
  localparam logic [7:0] CFG_BTN = 8'(N_BUTTONS);
  localparam logic [7:0] CFG_SW  = 8'(N_SWITCHES);

  logic [N-1:0] in_s;
  logic [N-1:0] deb_s;
  logic [N-1:0] chg_s;
  logic [N-1:0] rise_set_s;
  logic [N-1:0] fall_set_s;
  logic [N-1:0] rise_clr_s;
  logic [N-1:0] fall_clr_s;
  logic [N-1:0] rise_r;
  logic [N-1:0] fall_r;
  bus_state_e   state_r;
  logic         ack_r;
  logic [31:0]  rd_data_r;
  logic [31:0]  rd_mux_s;
  logic [1:0]   reg_sel_s;
  logic         req_s;
  logic         unused_s;

  assign in_s = {switches, buttons};

  for (genvar i = 0; i < N; i++) begin : g_deb
    button_input_regs_debouncer #(.PERIOD(DEBOUNCE_PERIOD)) u_deb (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .in     (in_s[i]),
      .out    (deb_s[i]),
      .change (chg_s[i])
    );
  end

  // A debouncer about to change from 0 is a rising edge; from 1, a falling one.
  assign rise_set_s = chg_s & ~deb_s;
  assign fall_set_s = chg_s & deb_s;

  assign reg_sel_s = wb.adr[3:2];
  assign req_s     = wb.cyc & wb.stb & (state_r == BUS_IDLE);
  assign unused_s  = ^{wb.adr, wb.dat_w};

  // Read multiplexer over the four word registers.
  always_comb begin
    rd_mux_s = 32'h0000_0000;
    case (reg_sel_s)
      BTN_REG_STATE:  rd_mux_s[N-1:0] = deb_s;
      BTN_REG_RISE:   rd_mux_s[N-1:0] = rise_r;
      BTN_REG_FALL:   rd_mux_s[N-1:0] = fall_r;
      BTN_REG_CONFIG: rd_mux_s = {16'h0000, CFG_SW, CFG_BTN};
      default:        rd_mux_s = 32'h0000_0000;
    endcase
  end

  // Write-1-to-clear masks, active only on the accepted write cycle.
  always_comb begin
    rise_clr_s = {N{1'b0}};
    fall_clr_s = {N{1'b0}};
    if (req_s && wb.we) begin
      case (reg_sel_s)
        BTN_REG_RISE: rise_clr_s = wb.dat_w[N-1:0];
        BTN_REG_FALL: fall_clr_s = wb.dat_w[N-1:0];
        default: begin
          rise_clr_s = {N{1'b0}};
          fall_clr_s = {N{1'b0}};
        end
      endcase
    end else begin
      rise_clr_s = {N{1'b0}};
      fall_clr_s = {N{1'b0}};
    end
  end

  // Bus handshake: one ack per request, read data captured on the acking edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= BUS_IDLE;
      ack_r     <= 1'b0;
      rd_data_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        BUS_IDLE: begin
          if (req_s) begin
            state_r <= BUS_ACK;
            ack_r   <= 1'b1;
            if (!wb.we) begin
              rd_data_r <= rd_mux_s;
            end
          end
        end
        BUS_ACK: begin
          state_r <= BUS_IDLE;
          ack_r   <= 1'b0;
        end
        default: begin
          state_r <= BUS_IDLE;
          ack_r   <= 1'b0;
        end
      endcase
    end
  end

  // Sticky edge flags; a new edge wins over a simultaneous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rise_r <= {N{1'b0}};
      fall_r <= {N{1'b0}};
    end else begin
      rise_r <= (rise_r & ~rise_clr_s) | rise_set_s;
      fall_r <= (fall_r & ~fall_clr_s) | fall_set_s;
    end
  end

  assign wb.ack   = ack_r;
  assign wb.dat_r = rd_data_r;

endmodule

// File: tb/tb_button_input_regs.sv
// Scoreboard bench for button_input_regs with a 4-cycle debounce period.
module tb_button_input_regs;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [3:0] buttons = 4'b0000;
  logic [3:0] switches = 4'b0000;

  wishbone wb_if ();

  button_input_regs #(
    .DEBOUNCE_PERIOD (4),
    .N_BUTTONS       (4),
    .N_SWITCHES      (4)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .buttons  (buttons),
    .switches (switches),
    .wb       (wb_if)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [31:0] exp;
    int          tag;
  } sb_t;

  sb_t sb_q[$];
  int  total = 0;
  int  bad = 0;
  int  tag_n = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Issue one access at posedge+1; returns at posedge+1 one idle cycle after the ack.
  task automatic bus(input logic we, input logic [1:0] rsel, input logic [31:0] wdat,
                     input logic [31:0] exp);
    int n;
    sb_t e;
    wb_if.cyc   = 1'b1;
    wb_if.stb   = 1'b1;
    wb_if.we    = we;
    wb_if.adr   = {28'h0000000, rsel, 2'b00};
    wb_if.dat_w = wdat;
    e.we = we;
    e.exp = exp;
    e.tag = tag_n;
    tag_n++;
    sb_q.push_back(e);
    n = 0;
    do begin
      @(posedge clk_i);
      #1;
      n++;
    end while (!wb_if.ack && n < 8);
    total++;
    if (!wb_if.ack || n != 1) begin
      bad++;
      $display("FAIL ack_latency tag=%0d: got %0d cycles expected 1", e.tag, n);
    end
    wb_if.cyc = 1'b0;
    wb_if.stb = 1'b0;
    wb_if.we  = 1'b0;
    tick(1);
  endtask

  // Monitor: every ack consumes one scoreboard entry; reads compare data.
  always @(negedge clk_i) begin : monitor
    sb_t e;
    if (!rst_i && wb_if.ack) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_ack: got ack expected none");
      end else begin
        e = sb_q.pop_front();
        if (!e.we) begin
          total++;
          if (wb_if.dat_r !== e.exp) begin
            bad++;
            $display("FAIL read tag=%0d: got %h expected %h", e.tag, wb_if.dat_r, e.exp);
          end
        end
      end
    end
  end

  initial begin
    wb_if.cyc = 1'b0;
    wb_if.stb = 1'b0;
    wb_if.we = 1'b0;
    wb_if.adr = 32'h0;
    wb_if.dat_w = 32'h0;
    tick(3);
    chk("reset_ack", {31'h0, wb_if.ack}, 32'h0);
    chk("reset_dat_r", wb_if.dat_r, 32'h0);
    rst_i = 1'b0;
    tick(1);

    // Register contents after reset.
    bus(1'b0, 2'd0, 32'h0, 32'h0000_0000);
    bus(1'b0, 2'd1, 32'h0, 32'h0000_0000);
    bus(1'b0, 2'd2, 32'h0, 32'h0000_0000);
    bus(1'b0, 2'd3, 32'h0, 32'h0000_0404);

    // Clean step on button 0: read acked on E+5 still sees 0, later reads see 1.
    buttons = 4'b0001;
    tick(5);
    bus(1'b0, 2'd0, 32'h0, 32'h0000_0000);
    bus(1'b0, 2'd0, 32'h0, 32'h0000_0001);
    bus(1'b0, 2'd1, 32'h0, 32'h0000_0001);

    // Three-cycle glitch on button 1 never debounces.
    buttons = 4'b0011;
    tick(3);
    buttons = 4'b0001;
    tick(8);
    bus(1'b0, 2'd0, 32'h0, 32'h0000_0001);
    bus(1'b0, 2'd1, 32'h0, 32'h0000_0001);

    // W1C: writing 0 keeps the flag, writing 1 clears it.
    bus(1'b1, 2'd1, 32'h0000_0000, 32'h0);
    bus(1'b0, 2'd1, 32'h0, 32'h0000_0001);
    bus(1'b1, 2'd1, 32'h0000_0001, 32'h0);
    bus(1'b0, 2'd1, 32'h0, 32'h0000_0000);

    // Clear of RISE bit 2 lands on the edge deb[2] rises: set wins.
    buttons = 4'b0101;
    tick(5);
    bus(1'b1, 2'd1, 32'h0000_0004, 32'h0);
    bus(1'b0, 2'd1, 32'h0, 32'h0000_0004);
    bus(1'b0, 2'd0, 32'h0, 32'h0000_0005);

    // Falling edge on button 0 and rising edge on switch 1.
    buttons = 4'b0100;
    switches = 4'b0010;
    tick(8);
    bus(1'b0, 2'd0, 32'h0, 32'h0000_0024);
    bus(1'b0, 2'd1, 32'h0, 32'h0000_0024);
    bus(1'b0, 2'd2, 32'h0, 32'h0000_0001);
    bus(1'b1, 2'd2, 32'h0000_0001, 32'h0);
    bus(1'b0, 2'd2, 32'h0, 32'h0000_0000);

    // Writes to read-only registers are acked and ignored.
    bus(1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0);
    bus(1'b0, 2'd0, 32'h0, 32'h0000_0024);
    bus(1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0);
    bus(1'b0, 2'd3, 32'h0, 32'h0000_0404);

    // Reset while ack is high: everything clears before the next clock edge.
    wb_if.cyc = 1'b1;
    wb_if.stb = 1'b1;
    wb_if.we  = 1'b0;
    wb_if.adr = 32'h0000_0004;
    @(posedge clk_i);
    #1;
    chk("pre_reset_ack", {31'h0, wb_if.ack}, 32'h1);
    chk("pre_reset_dat_r", wb_if.dat_r, 32'h0000_0024);
    rst_i = 1'b1;
    #1;
    chk("async_ack", {31'h0, wb_if.ack}, 32'h0);
    chk("async_dat_r", wb_if.dat_r, 32'h0);
    chk("async_state", {24'h0, dut.deb_s}, 32'h0);
    chk("async_rise", {24'h0, dut.rise_r}, 32'h0);
    chk("async_fall", {24'h0, dut.fall_r}, 32'h0);
    wb_if.cyc = 1'b0;
    wb_if.stb = 1'b0;
    tick(2);
    rst_i = 1'b0;
    tick(1);

    // Inputs held high re-debounce after reset and raise RISE flags.
    bus(1'b0, 2'd0, 32'h0, 32'h0000_0000);
    tick(8);
    bus(1'b0, 2'd0, 32'h0, 32'h0000_0024);
    bus(1'b0, 2'd1, 32'h0, 32'h0000_0024);
    bus(1'b0, 2'd2, 32'h0, 32'h0000_0000);

    tick(2);
    chk("scoreboard_empty", sb_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_input_regs.md
# button_input_regs

Wishbone classic responder that exposes the board buttons and switches as readable registers, the read-side counterpart to the LED output responder. Each input bit is synchronised and debounced. The debounced state is readable, and sticky rising/falling-edge flags are cleared by writing 1. It sits on the shared `wishbone` interface next to the LED output block, so a bus initiator (e.g. a soft CPU) can poll the user inputs.

## Interface
- `DEBOUNCE_PERIOD`, 5_000_000: consecutive stable cycles required before a debounced bit changes; must be ≥ 2.
- `N_BUTTONS`, 4: number of button inputs.
- `N_SWITCHES`, 4: number of switch inputs. `N_BUTTONS + N_SWITCHES` must be ≤ 32.

- `clk_i`  in  1: single clock, shared with the `wishbone` interface.
- `rst_i`  in  1: asynchronous, active-high reset.
- `buttons`  in  N_BUTTONS: raw, asynchronous button levels.
- `switches`  in  N_SWITCHES: raw, asynchronous switch levels.
- `wb`  `wishbone.slave` modport: signals `cyc`, `stb`, `we`, `adr`, `dat_w` (32), `dat_r` (32), `ack`. Decoding uses word-address bits `adr[3:2]`.

## Operation
- Input vector `in = {switches, buttons}` (N = N_BUTTONS+N_SWITCHES bits); bit i uses one debouncer.
- Synchroniser: 2-FF chain per bit, giving `sync[i]`.
- Debouncer per bit:
  - `cnt` width is `$clog2(DEBOUNCE_PERIOD)`.
  - If `sync == deb`, then `cnt <= 0`.
  - Otherwise, if `cnt == DEBOUNCE_PERIOD-1`, then `deb <= sync` and `cnt <= 0`.
  - Otherwise, `cnt <= cnt+1`.
  - Any glitch back to `deb` restarts the count.
- Edge flags:
  - `rise[i]` is set on the same edge that `deb[i]` goes 0→1.
  - `fall[i]` is set on the same edge that `deb[i]` goes 1→0.
  - Flags are sticky until cleared.
- Register map (`adr[3:2]`):
  - 0 STATE, RO: `dat_r[N-1:0] = deb`, upper bits 0.
  - 1 RISE, R/W1C: `rise`. Writing `dat_w[i]=1` clears bit i.
  - 2 FALL, R/W1C: `fall`, same rule as RISE.
  - 3 CONFIG, RO: `{16'h0, N_SWITCHES[7:0], N_BUTTONS[7:0]}`.
- Writes to STATE or CONFIG are acknowledged and ignored.
- Simultaneous W1C clear and new edge on the same bit in the same cycle: set wins, so the flag stays 1.
- No error/retry: every access is acked. No `sel` granularity; full-word access only.

## Timing
- Reset values:
  - `ack` = 0, `dat_r` = 0.
  - All sync FFs, `deb`, `cnt`, `rise`, `fall` = 0.
  - After reset, inputs held high produce RISE flags once debounced.
- Bus handshake: `ack <= cyc & stb & ~ack`.
  - `ack` goes high exactly one cycle after `cyc&stb` is first sampled, and stays high for one cycle.
  - The initiator drops or renews `stb`. A held `stb` yields one ack every 2 cycles.
- Read data: `dat_r` is registered on the same edge that raises `ack`, from register contents before that edge. `dat_r` holds its value until the next read.
- W1C write takes effect on the edge that raises `ack`.
- Latency: a clean input step sampled on edge E reaches `sync` at E+1. `deb` and the edge flag update at edge E+1+DEBOUNCE_PERIOD.
- Reset asserted mid-transfer: `ack` drops immediately. The transfer is lost, and the initiator must reissue it.

## Structure
- Shared `types` package:
  - Register index constants `BTN_REG_STATE=2'd0`, `BTN_REG_RISE=2'd1`, `BTN_REG_FALL=2'd2`, `BTN_REG_CONFIG=2'd3`.
  - Default `DEBOUNCE_PERIOD` constant, so the top level and this block agree.
- Sub-module `debouncer`: 1-bit, parameter `PERIOD`, ports `clk_i`, `rst_i`, `in`, `out`. It contains the 2-FF synchroniser and counter and is instantiated N times via `generate`.
- Top block: the bus FSM (IDLE / ACK, equivalent to the `ack` register), the register file, and the edge logic.

## Test plan
Bench runs with `DEBOUNCE_PERIOD=4`.
- Reset, then read all four registers → STATE=0, RISE=0, FALL=0, CONFIG=`0x00000404`. Each `ack` arrives exactly 1 cycle after `stb`.
- Set `buttons=4'b0001` cleanly on edge E → STATE bit 0 and RISE bit 0 both become 1 at edge E+5, not earlier. Read STATE=`0x1`, RISE=`0x1`.
- Toggle `buttons[1]` for 3 cycles then back (glitch) → STATE and RISE are unchanged (0).
- With RISE=`0x1`, write RISE=`0x1` → RISE reads 0. Write `0x0` to a set flag → flag unchanged.
- Schedule a W1C of RISE bit 2 on the same edge that `deb[2]` rises → RISE bit 2 reads 1.
- Assert `rst_i` while `ack` is pending and with flags set → `ack`, `dat_r`, STATE, RISE and FALL are all 0 immediately, asynchronously, before the next clock edge.
